// File: rtl/sr_latch_driver_if.sv
// Command handshake and latch drive/readback bundle for sr_latch_driver.
// The master side issues commands and models the latch; the slave side is the driver.
interface sr_latch_driver_if;
    logic req_valid;
    logic req_value;
    logic req_ready;
    logic s;
    logic r;
    logic q_fb;
    logic done;
    logic err;
    logic state_o;

    modport master (
        output req_valid, req_value, q_fb,
        input  req_ready, s, r, done, err, state_o
    );

    modport slave (
        input  req_valid, req_value, q_fb,
        output req_ready, s, r, done, err, state_o
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives an external SR latch with guarded set/reset pulses and verifies the
// synchronized Q readback after a settle window; fixed latency per command.
module sr_latch_driver #(
    parameter int PULSE_CYCLES  = 4,
    parameter int DEAD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_driver_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DEAD, PULSE, CHECK} state_t;

    // Counters load N-1 on entry and leave the phase at zero, so they never wrap.
    localparam logic [7:0] DEAD_LD   = 8'(DEAD_CYCLES - 1);
    localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       target, target_nx;
    logic [1:0] q_sync;
    logic       s_q, r_q, done_q, err_q, state_o_q;
    logic       s_nx, r_nx, done_nx, err_nx, state_o_nx;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        target_nx  = target;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        state_o_nx = state_o_q;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nx  = DEAD;
                    cnt_nx    = DEAD_LD;
                    target_nx = bus.req_value;
                end
            end
            DEAD: begin
                if (cnt == 8'd0) begin
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            PULSE: begin
                if (cnt == 8'd0) begin
                    state_nx = CHECK;
                    cnt_nx   = SETTLE_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            CHECK: begin
                if (cnt == 8'd0) begin
                    // q_sync[1] here is the value seen in the last CHECK cycle
                    state_nx   = IDLE;
                    cnt_nx     = 8'd0;
                    done_nx    = 1'b1;
                    err_nx     = (q_sync[1] != target);
                    state_o_nx = target;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
        // Drives follow the next state so s/r are flops aligned with the phase.
        s_nx = (state_nx == PULSE) &&  target_nx;
        r_nx = (state_nx == PULSE) && !target_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            target    <= 1'b0;
            q_sync    <= 2'b00;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            state_o_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            target    <= target_nx;
            q_sync    <= {q_sync[0], bus.q_fb};
            s_q       <= s_nx;
            r_q       <= r_nx;
            done_q    <= done_nx;
            err_q     <= err_nx;
            state_o_q <= state_o_nx;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.state_o   = state_o_q;
endmodule
